// File: rtl/tape_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tape_unit
//  Purpose  : Tape-machine execution unit. It holds the tape pointer,
//             applies pointer moves in a single cycle and runs
//             cell-modifying or cell-reading commands through a one-cycle
//             EXEC state. The tape memory is external, with a
//             combinational read and a synchronous write.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    width_addr        tape address (pointer) width
//    width_data        tape cell width
//    width_cnt         repeat-count width
//  Ports
//    clk_in            sole clock, rising edge
//    reset_n_in        asynchronous active-low reset
//    cmd_valid_in      command offered
//    cmd_ready_out     command accepted this cycle (high only in IDLE)
//    cmd_op_in         0/7 NOP, 1 INC, 2 DEC, 3 RIGHT, 4 LEFT, 5 OUT, 6 IN
//    cmd_cnt_in        repeat count for INC/DEC/RIGHT/LEFT
//    io_data_in        value stored by IN
//    io_data_out       value read by the last OUT
//    io_valid_out      one-cycle pulse after OUT completes
//    mem_addr_out      tape address, always the pointer
//    mem_data_in       tape read data at mem_addr_out
//    mem_data_out      tape write data (zero when not writing)
//    mem_is_write_out  tape write strobe
//    cell_zero_out     current cell is zero (forced low during EXEC)
//    err_out           sticky pointer-wrap flag (TAPE_BOUNDS_ERR_EN only)
//  Configuration
//    TAPE_BOUNDS_ERR_EN  when defined, adds err_out and wrap detection
// ============================================================================
module tape_unit #(
   parameter int width_addr = 16,
   parameter int width_data = 16,
   parameter int width_cnt  = 8
) (
   input  logic                  clk_in,
   input  logic                  reset_n_in,
   input  logic                  cmd_valid_in,
   output logic                  cmd_ready_out,
   input  logic [2:0]            cmd_op_in,
   input  logic [width_cnt-1:0]  cmd_cnt_in,
   input  logic [width_data-1:0] io_data_in,
   output logic [width_data-1:0] io_data_out,
   output logic                  io_valid_out,
   output logic [width_addr-1:0] mem_addr_out,
   input  logic [width_data-1:0] mem_data_in,
   output logic [width_data-1:0] mem_data_out,
   output logic                  mem_is_write_out,
   output logic                  cell_zero_out
`ifdef TAPE_BOUNDS_ERR_EN
   ,
   output logic                  err_out
`endif
);

   // ------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------
   localparam logic [0:0] c_ST_IDLE = 1'b0;
   localparam logic [0:0] c_ST_EXEC = 1'b1;

   localparam logic [2:0] c_OP_NOP0  = 3'd0;
   localparam logic [2:0] c_OP_INC   = 3'd1;
   localparam logic [2:0] c_OP_DEC   = 3'd2;
   localparam logic [2:0] c_OP_RIGHT = 3'd3;
   localparam logic [2:0] c_OP_LEFT  = 3'd4;
   localparam logic [2:0] c_OP_OUT   = 3'd5;
   localparam logic [2:0] c_OP_IN    = 3'd6;
   localparam logic [2:0] c_OP_NOP7  = 3'd7;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [0:0]            state_q,    state_d;
   logic [width_addr-1:0] ptr_q,      ptr_d;
   logic [2:0]            op_q,       op_d;
   logic [width_cnt-1:0]  cnt_q,      cnt_d;
   logic [width_data-1:0] data_q,     data_d;
   logic [width_data-1:0] io_data_q,  io_data_d;
   logic                  io_valid_q, io_valid_d;

   logic                  accept;
   logic [width_addr-1:0] cnt_addr;   // count resized to the pointer width
   logic [width_data-1:0] cnt_data;   // latched count resized to the cell width

   assign cmd_ready_out = (state_q == c_ST_IDLE);
   assign accept        = cmd_valid_in && cmd_ready_out;

   // Casts zero-extend or truncate; either way the arithmetic below is
   // modulo the destination width, which is exactly the wrap behaviour.
   assign cnt_addr = width_addr'(cmd_cnt_in);
   assign cnt_data = width_data'(cnt_q);

`ifdef TAPE_BOUNDS_ERR_EN
   // Wrap detection is done one bit wider than the larger of pointer and
   // count so that the carry/borrow is visible for any parameterisation.
   localparam int c_WS = ((width_addr > width_cnt) ? width_addr : width_cnt) + 1;

   logic              err_q, err_d;
   logic [c_WS-1:0]   ptr_wide;
   logic [c_WS-1:0]   cnt_wide;
   logic [c_WS-1:0]   ptr_max_wide;
   logic              wrap_right;
   logic              wrap_left;

   assign ptr_wide     = c_WS'(ptr_q);
   assign cnt_wide     = c_WS'(cmd_cnt_in);
   assign ptr_max_wide = c_WS'({width_addr{1'b1}});
   assign wrap_right   = (ptr_wide + cnt_wide) > ptr_max_wide;
   assign wrap_left    = cnt_wide > ptr_wide;
   assign err_out      = err_q;
`endif

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      op_d       = op_q;
      cnt_d      = cnt_q;
      data_d     = data_q;
      io_data_d  = io_data_q;
      io_valid_d = 1'b0;
`ifdef TAPE_BOUNDS_ERR_EN
      err_d      = err_q;
`endif

      case (state_q)
         c_ST_IDLE: begin
            if (accept) begin
               case (cmd_op_in)
                  // Pointer moves complete at the accept edge so the
                  // unit can take a new command every cycle.
                  c_OP_RIGHT: begin
                     ptr_d = ptr_q + cnt_addr;
`ifdef TAPE_BOUNDS_ERR_EN
                     if (wrap_right) err_d = 1'b1;
`endif
                  end
                  c_OP_LEFT: begin
                     ptr_d = ptr_q - cnt_addr;
`ifdef TAPE_BOUNDS_ERR_EN
                     if (wrap_left) err_d = 1'b1;
`endif
                  end
                  c_OP_INC, c_OP_DEC, c_OP_OUT, c_OP_IN: begin
                     op_d    = cmd_op_in;
                     cnt_d   = cmd_cnt_in;
                     data_d  = io_data_in;
                     state_d = c_ST_EXEC;
                  end
                  c_OP_NOP0, c_OP_NOP7: begin
                     // Accepted and discarded.
                  end
                  default: begin
                  end
               endcase
            end
         end

         c_ST_EXEC: begin
            state_d = c_ST_IDLE;
            if (op_q == c_OP_OUT) begin
               io_data_d  = mem_data_in;
               io_valid_d = 1'b1;
            end
         end

         default: begin
            state_d = c_ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state_q    <= c_ST_IDLE;
         ptr_q      <= '0;
         op_q       <= c_OP_NOP0;
         cnt_q      <= '0;
         data_q     <= '0;
         io_data_q  <= '0;
         io_valid_q <= 1'b0;
`ifdef TAPE_BOUNDS_ERR_EN
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         op_q       <= op_d;
         cnt_q      <= cnt_d;
         data_q     <= data_d;
         io_data_q  <= io_data_d;
         io_valid_q <= io_valid_d;
`ifdef TAPE_BOUNDS_ERR_EN
         err_q      <= err_d;
`endif
      end
   end

   // ------------------------------------------------------------------
   // Memory write path. Decoded purely from the registered state, so an
   // asynchronous reset during EXEC drops the strobe at once and the
   // pending write never reaches the memory.
   // ------------------------------------------------------------------
   always_comb begin
      mem_is_write_out = 1'b0;
      mem_data_out     = '0;
      if (state_q == c_ST_EXEC) begin
         case (op_q)
            c_OP_INC: begin
               mem_is_write_out = 1'b1;
               mem_data_out     = mem_data_in + cnt_data;
            end
            c_OP_DEC: begin
               mem_is_write_out = 1'b1;
               mem_data_out     = mem_data_in - cnt_data;
            end
            c_OP_IN: begin
               mem_is_write_out = 1'b1;
               mem_data_out     = data_q;
            end
            default: begin
            end
         endcase
      end
   end

   assign mem_addr_out  = ptr_q;
   assign io_data_out   = io_data_q;
   assign io_valid_out  = io_valid_q;
   // Loop control must not see the pre-write value while a write is pending.
   assign cell_zero_out = (state_q == c_ST_IDLE) && (mem_data_in == '0);

endmodule
`default_nettype wire

// File: tb/tb_tape_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tape_unit
//  Purpose  : Self-checking bench for tape_unit. Directed steps followed by
//             random commands, checked against a behavioural tape model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tape_unit;

   logic        clk_in = 1'b0;
   logic        reset_n_in;
   logic        cmd_valid_in;
   logic        cmd_ready_out;
   logic [2:0]  cmd_op_in;
   logic [7:0]  cmd_cnt_in;
   logic [15:0] io_data_in;
   logic [15:0] io_data_out;
   logic        io_valid_out;
   logic [15:0] mem_addr_out;
   logic [15:0] mem_data_in;
   logic [15:0] mem_data_out;
   logic        mem_is_write_out;
   logic        cell_zero_out;
`ifdef TAPE_BOUNDS_ERR_EN
   logic        err_out;
`endif

   int checks   = 0;
   int failures = 0;

   // Tape memory attached to the DUT: combinational read, write on the edge.
   logic [15:0] tape [0:65535];
   assign mem_data_in = tape[mem_addr_out];
   always @(posedge clk_in) if (mem_is_write_out) tape[mem_addr_out] <= mem_data_out;
   initial for (int i = 0; i < 65536; i++) tape[i] = 16'h0;

   always #5 clk_in = ~clk_in;

   tape_unit #(.width_addr(16), .width_data(16), .width_cnt(8)) dut (
      .clk_in           (clk_in),
      .reset_n_in       (reset_n_in),
      .cmd_valid_in     (cmd_valid_in),
      .cmd_ready_out    (cmd_ready_out),
      .cmd_op_in        (cmd_op_in),
      .cmd_cnt_in       (cmd_cnt_in),
      .io_data_in       (io_data_in),
      .io_data_out      (io_data_out),
      .io_valid_out     (io_valid_out),
      .mem_addr_out     (mem_addr_out),
      .mem_data_in      (mem_data_in),
      .mem_data_out     (mem_data_out),
      .mem_is_write_out (mem_is_write_out),
      .cell_zero_out    (cell_zero_out)
`ifdef TAPE_BOUNDS_ERR_EN
      ,
      .err_out          (err_out)
`endif
   );

   // Reference model: abstract tape as an integer-indexed array.
   int m_mem [0:65535];
   int m_ptr;
   int m_io;
   bit m_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_err(input bit exp);
`ifdef TAPE_BOUNDS_ERR_EN
      check("err_out", {31'd0, err_out}, {31'd0, exp});
`else
      if (exp) begin end
`endif
   endtask

   // Issue one command and check it through to completion against the model.
   task automatic do_cmd(input int op, input int cnt, input int data);
      bit exec;
      int n;
      check("ready_before", {31'd0, cmd_ready_out}, 32'd1);
      cmd_valid_in = 1'b1;
      cmd_op_in    = op[2:0];
      cmd_cnt_in   = cnt[7:0];
      io_data_in   = data[15:0];
      @(posedge clk_in); #1;
      cmd_valid_in = 1'b0;

      exec = 1'b0;
      case (op)
         1: begin m_mem[m_ptr] = (m_mem[m_ptr] + cnt) % 65536; exec = 1'b1; end
         2: begin m_mem[m_ptr] = (m_mem[m_ptr] - cnt + 65536) % 65536; exec = 1'b1; end
         3: begin n = m_ptr + cnt; if (n > 65535) begin m_err = 1'b1; n -= 65536; end m_ptr = n; end
         4: begin n = m_ptr - cnt; if (n < 0) begin m_err = 1'b1; n += 65536; end m_ptr = n; end
         5: begin m_io = m_mem[m_ptr]; exec = 1'b1; end
         6: begin m_mem[m_ptr] = data % 65536; exec = 1'b1; end
         default: begin end
      endcase

      check("io_valid_idle", {31'd0, io_valid_out}, 32'd0);
      if (exec) begin
         check("ready_exec", {31'd0, cmd_ready_out}, 32'd0);
         check("cell_zero_exec", {31'd0, cell_zero_out}, 32'd0);
         check("we_exec", {31'd0, mem_is_write_out}, (op == 5) ? 32'd0 : 32'd1);
         check("wdata_exec", {16'd0, mem_data_out}, (op == 5) ? 32'd0 : m_mem[m_ptr]);
         check("addr_exec", {16'd0, mem_addr_out}, m_ptr);
         @(posedge clk_in); #1;
         check("io_valid_done", {31'd0, io_valid_out}, (op == 5) ? 32'd1 : 32'd0);
         check("tape_cell", {16'd0, tape[m_ptr]}, m_mem[m_ptr]);
      end
      check("ready_after", {31'd0, cmd_ready_out}, 32'd1);
      check("we_idle", {31'd0, mem_is_write_out}, 32'd0);
      check("wdata_idle", {16'd0, mem_data_out}, 32'd0);
      check("addr", {16'd0, mem_addr_out}, m_ptr);
      check("cell_zero", {31'd0, cell_zero_out}, (m_mem[m_ptr] == 0) ? 32'd1 : 32'd0);
      check("io_data", {16'd0, io_data_out}, m_io);
      check_err(m_err);
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) m_mem[i] = 0;
      m_ptr = 0; m_io = 0; m_err = 1'b0;
      reset_n_in   = 1'b0;
      cmd_valid_in = 1'b0;
      cmd_op_in    = 3'd0;
      cmd_cnt_in   = 8'd0;
      io_data_in   = 16'd0;

      // Reset state
      repeat (2) @(posedge clk_in);
      #1;
      check("rst_we", {31'd0, mem_is_write_out}, 32'd0);
      check("rst_wdata", {16'd0, mem_data_out}, 32'd0);
      check("rst_addr", {16'd0, mem_addr_out}, 32'd0);
      check("rst_io_valid", {31'd0, io_valid_out}, 32'd0);
      check("rst_io_data", {16'd0, io_data_out}, 32'd0);
      check_err(1'b0);
      reset_n_in = 1'b1;
      check("ready_after_release", {31'd0, cmd_ready_out}, 32'd1);

      // INC 3 on cell 0 at address 0
      do_cmd(1, 3, 0);
      check("inc3_cell0", {16'd0, tape[0]}, 32'd3);

      // Back-to-back pointer moves
      do_cmd(3, 5, 0);
      check("right5", {16'd0, mem_addr_out}, 32'd5);
      do_cmd(3, 5, 0);
      check("right10", {16'd0, mem_addr_out}, 32'd10);
      do_cmd(4, 2, 0);
      check("left8", {16'd0, mem_addr_out}, 32'd8);

      // IN then OUT at address 8
      do_cmd(6, 0, 16'h41);
      do_cmd(5, 0, 0);
      check("out_data", {16'd0, io_data_out}, 32'h41);
      check("out_cell_zero", {31'd0, cell_zero_out}, 32'd0);
      @(posedge clk_in); #1;
      check("out_single_pulse", {31'd0, io_valid_out}, 32'd0);

      // DEC below zero and pointer wrap below 0
      do_cmd(4, 7, 0);
      do_cmd(2, 1, 0);
      check("dec_wrap", {16'd0, tape[1]}, 32'hFFFF);
      do_cmd(4, 1, 0);
      check_err(1'b0);
      do_cmd(4, 1, 0);
      check("left_wrap", {16'd0, mem_addr_out}, 32'hFFFF);
      check_err(1'b1);
      do_cmd(3, 2, 0);
      check("right_wrap", {16'd0, mem_addr_out}, 32'd1);

      // Zero counts and NOPs
      do_cmd(1, 0, 0);
      check("inc0_unchanged", {16'd0, tape[1]}, 32'hFFFF);
      do_cmd(3, 0, 0);
      do_cmd(0, 9, 0);
      do_cmd(7, 9, 0);
      check("nop_addr", {16'd0, mem_addr_out}, 32'd1);

      // Reset during EXEC of INC at address 4
      do_cmd(3, 3, 0);
      cmd_valid_in = 1'b1; cmd_op_in = 3'd1; cmd_cnt_in = 8'd2;
      @(posedge clk_in); #1;
      cmd_valid_in = 1'b0;
      check("abort_we_before", {31'd0, mem_is_write_out}, 32'd1);
      #2 reset_n_in = 1'b0;
      #1;
      check("abort_we", {31'd0, mem_is_write_out}, 32'd0);
      check("abort_wdata", {16'd0, mem_data_out}, 32'd0);
      check("abort_addr", {16'd0, mem_addr_out}, 32'd0);
      @(posedge clk_in); #1;
      check("abort_cell", {16'd0, tape[4]}, 32'd0);
      m_ptr = 0; m_io = 0; m_err = 1'b0;
      check_err(1'b0);
      reset_n_in = 1'b1;
      check("abort_ready", {31'd0, cmd_ready_out}, 32'd1);

      // Random commands against the model
      for (int k = 0; k < 300; k++) begin
         do_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 65535)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
